// File: rtl/bp_common_pkg.sv
// Shared width helpers and error-cause encoding for the LCE response arbiter
// and its multi-source credit counter.
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_arb_err_none    = 2'd0,
    e_arb_err_retract = 2'd1,
    e_arb_err_credit  = 2'd2
  } bp_lce_arb_err_e;

  // A count that can reach max_credits inclusive.
  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

  // A wait counter that saturates at starve_limit inclusive.
  function automatic int wait_width(input int starve_limit);
    return $clog2(starve_limit + 1);
  endfunction

endpackage

// File: rtl/bp_lce_multi_credit_counter.sv
// Outstanding-request counter: one send and up to num_ret_p returns per cycle,
// clamped to [0, max_credits_p] with a sticky over/underflow flag.
module bp_lce_multi_credit_counter
  import bp_common_pkg::*;
#(
  parameter int max_credits_p = 8,
  parameter int num_ret_p     = 4,
  localparam int cnt_width_lp = credit_width(max_credits_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    send_i,
  input  logic [num_ret_p-1:0]    return_i,
  output logic [cnt_width_lp-1:0] count_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    err_o
);

  localparam int ret_width_lp = $clog2(num_ret_p + 1);
  localparam int sum_width_lp =
    ((cnt_width_lp > ret_width_lp) ? cnt_width_lp : ret_width_lp) + 2;

  logic [cnt_width_lp-1:0]        count_r;
  logic                           err_r;
  logic [ret_width_lp-1:0]        ret_cnt;
  logic signed [sum_width_lp-1:0] next_sum;
  logic                           under, over;
  logic [cnt_width_lp-1:0]        count_n;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ret_cnt = '0;
    for (int i = 0; i < num_ret_p; i++)
      ret_cnt = ret_cnt + ret_width_lp'(return_i[i]);

    next_sum = sum_width_lp'(count_r) + sum_width_lp'(send_i)
             - sum_width_lp'(ret_cnt);
    under    = (next_sum < 0);
    over     = !under && (next_sum > $signed(sum_width_lp'(max_credits_p)));

    count_n = next_sum[cnt_width_lp-1:0];
    if (under)     count_n = '0;
    else if (over) count_n = cnt_width_lp'(max_credits_p);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_n;
      if (under || over) err_r <= 1'b1;
    end
  end

  assign count_o = count_r;
  assign full_o  = (count_r == cnt_width_lp'(max_credits_p));
  assign empty_o = (count_r == '0);
  assign err_o   = err_r;

endmodule

// File: rtl/bp_lce_resp_credit_arb.sv
// N-source LCE response arbiter (fixed priority, grant lock, starvation boost)
// with integrated credit counter. Optional stats: BP_LCE_RESP_ARB_STATS_EN.
module bp_lce_resp_credit_arb
  import bp_common_pkg::*;
#(
  parameter int num_src_p      = 2,
  parameter int resp_width_p   = 64,
  parameter int num_ret_p      = 4,
  parameter int max_credits_p  = 8,
  parameter int starve_limit_p = 15,
  localparam int credit_width_lp = credit_width(max_credits_p),
  localparam int wait_width_lp   = wait_width(starve_limit_p),
  localparam int id_width_lp     = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_src_p*resp_width_p-1:0] src_resp_i,
  input  logic [num_src_p-1:0]              src_v_i,
  output logic [num_src_p-1:0]              src_yumi_o,
  output logic [resp_width_p-1:0]           lce_resp_o,
  output logic                              lce_resp_v_o,
  input  logic                              lce_resp_ready_i,
  input  logic                              req_v_i,
  input  logic                              req_ready_i,
  input  logic [num_ret_p-1:0]              credit_return_i,
  output logic [credit_width_lp-1:0]        credit_count_o,
  output logic                              credits_full_o,
  output logic                              credits_empty_o,
  output logic                              credit_err_o,
  output logic                              boost_o
`ifdef BP_LCE_RESP_ARB_STATS_EN
  ,
  output logic [31:0]                       stall_cycles_o,
  output logic [15:0]                       boost_grants_o
`endif
);

  logic                   lock_v_r;
  logic [id_width_lp-1:0] lock_id_r;
  logic                   lock_boost_r;
  logic                   retract_err_r;
  logic [num_src_p-1:0]   starving;
  logic [id_width_lp-1:0] grant_id;
  logic                   grant_boost;
  logic                   handshake;
  logic                   credit_err;

  // Lock overrides everything; otherwise starving sources beat static priority.
  // Descending loops leave the lowest qualifying index as the winner.
  always_comb begin
    grant_id    = '0;
    grant_boost = 1'b0;
    if (lock_v_r) begin
      grant_id    = lock_id_r;
      grant_boost = lock_boost_r;
    end else if (|starving) begin
      grant_boost = 1'b1;
      for (int i = num_src_p - 1; i >= 0; i--)
        if (starving[i]) grant_id = id_width_lp'(i);
    end else begin
      for (int i = num_src_p - 1; i >= 0; i--)
        if (src_v_i[i]) grant_id = id_width_lp'(i);
    end
  end

  assign lce_resp_v_o = src_v_i[grant_id] & ~reset_i;
  assign lce_resp_o   = src_resp_i[grant_id*resp_width_p +: resp_width_p];
  assign handshake    = lce_resp_v_o & lce_resp_ready_i;
  assign boost_o      = grant_boost;

  always_comb begin
    src_yumi_o           = '0;
    src_yumi_o[grant_id] = handshake;
  end

  // The lock holds only while the granted packet is valid but back-pressured;
  // a retracting source therefore unlocks itself and is flagged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_v_r      <= 1'b0;
      lock_id_r     <= '0;
      lock_boost_r  <= 1'b0;
      retract_err_r <= 1'b0;
    end else begin
      lock_v_r     <= lce_resp_v_o & ~lce_resp_ready_i;
      lock_id_r    <= grant_id;
      lock_boost_r <= grant_boost;
      if (lock_v_r && !src_v_i[lock_id_r]) retract_err_r <= 1'b1;
    end
  end

  for (genvar i = 0; i < num_src_p; i++) begin : g_wait
    logic [wait_width_lp-1:0] wait_r;

    always_ff @(posedge clk_i) begin
      if (reset_i)
        wait_r <= '0;
      else if (!src_v_i[i] || src_yumi_o[i])
        wait_r <= '0;
      else if (wait_r != wait_width_lp'(starve_limit_p))
        wait_r <= wait_r + 1'b1;
    end

    assign starving[i] = (wait_r == wait_width_lp'(starve_limit_p));
  end

  bp_lce_multi_credit_counter #(
    .max_credits_p(max_credits_p),
    .num_ret_p    (num_ret_p)
  ) credit_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .send_i  (req_v_i & req_ready_i),
    .return_i(credit_return_i),
    .count_o (credit_count_o),
    .full_o  (credits_full_o),
    .empty_o (credits_empty_o),
    .err_o   (credit_err)
  );

  assign credit_err_o = credit_err | retract_err_r;

`ifdef BP_LCE_RESP_ARB_STATS_EN
  logic [31:0] stall_cycles_r;
  logic [15:0] boost_grants_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cycles_r <= '0;
      boost_grants_r <= '0;
    end else begin
      if (lce_resp_v_o && !lce_resp_ready_i && !(&stall_cycles_r))
        stall_cycles_r <= stall_cycles_r + 1'b1;
      if (handshake && grant_boost && !(&boost_grants_r))
        boost_grants_r <= boost_grants_r + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cycles_r;
  assign boost_grants_o = boost_grants_r;
`endif

endmodule

// File: tb/tb_bp_lce_resp_credit_arb.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a cycle-level behavioural model of the arbiter and credits.
module tb_bp_lce_resp_credit_arb;
  import bp_common_pkg::*;

  localparam int NS = 3;
  localparam int RW = 16;
  localparam int NR = 4;
  localparam int MC = 8;
  localparam int SL = 3;
  localparam int CW = $clog2(MC + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [NS*RW-1:0] src_resp;
  logic [NS-1:0] src_v;
  logic [NS-1:0] src_yumi;
  logic [RW-1:0] lce_resp;
  logic          lce_resp_v;
  logic          lce_resp_ready;
  logic          req_v;
  logic          req_ready;
  logic [NR-1:0] credit_return;
  logic [CW-1:0] credit_count;
  logic          credits_full;
  logic          credits_empty;
  logic          credit_err;
  logic          boost;
`ifdef BP_LCE_RESP_ARB_STATS_EN
  logic [31:0]   stall_cycles;
  logic [15:0]   boost_grants;
  int unsigned   m_stall;
  int unsigned   m_bgrants;
`endif

  always #5 clk = ~clk;

  bp_lce_resp_credit_arb #(
    .num_src_p     (NS),
    .resp_width_p  (RW),
    .num_ret_p     (NR),
    .max_credits_p (MC),
    .starve_limit_p(SL)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .src_resp_i      (src_resp),
    .src_v_i         (src_v),
    .src_yumi_o      (src_yumi),
    .lce_resp_o      (lce_resp),
    .lce_resp_v_o    (lce_resp_v),
    .lce_resp_ready_i(lce_resp_ready),
    .req_v_i         (req_v),
    .req_ready_i     (req_ready),
    .credit_return_i (credit_return),
    .credit_count_o  (credit_count),
    .credits_full_o  (credits_full),
    .credits_empty_o (credits_empty),
    .credit_err_o    (credit_err),
    .boost_o         (boost)
`ifdef BP_LCE_RESP_ARB_STATS_EN
    ,
    .stall_cycles_o  (stall_cycles),
    .boost_grants_o  (boost_grants)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int              m_lock = -1;     // locked source index, -1 when free
  bit              m_lock_boost;
  int              m_age [NS];      // cycles each source has waited
  int              m_count;
  bp_lce_arb_err_e m_err = e_arb_err_none;
  logic [NS-1:0]   m_yumi;          // expected yumi of the last cycle

  // One clock: drive at negedge, check #1 later, then advance the model.
  task automatic cycle(input logic [NS-1:0] v, input logic rdy, input logic rv,
                       input logic rr, input logic [NR-1:0] ret, input logic rst);
    int g;
    int starv;
    bit b;
    bit e_v;
    int n;
    @(negedge clk);
    reset          = rst;
    src_v          = v;
    lce_resp_ready = rdy;
    req_v          = rv;
    req_ready      = rr;
    credit_return  = ret;
    for (int i = 0; i < NS; i++) src_resp[i*RW +: RW] = RW'($urandom);
    #1;

    g = 0;
    b = 1'b0;
    if (m_lock >= 0) begin
      g = m_lock;
      b = m_lock_boost;
    end else begin
      starv = -1;
      for (int i = 0; i < NS; i++) if (m_age[i] == SL && starv < 0) starv = i;
      if (starv >= 0) begin
        g = starv;
        b = 1'b1;
      end else begin
        for (int i = NS - 1; i >= 0; i--) if (v[i]) g = i;
      end
    end
    e_v    = v[g] && !rst;
    m_yumi = (e_v && rdy) ? (NS'(1) << g) : '0;

    check("resp_v", lce_resp_v, e_v);
    check("yumi", src_yumi, m_yumi);
    if (e_v) begin
      check("resp_data", lce_resp, src_resp[g*RW +: RW]);
      check("boost", boost, b);
    end
    check("count", credit_count, m_count);
    check("full", credits_full, m_count == MC);
    check("empty", credits_empty, m_count == 0);
    check("err", credit_err, m_err != e_arb_err_none);
`ifdef BP_LCE_RESP_ARB_STATS_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("boost_grants", boost_grants, m_bgrants);
`endif

    if (rst) begin
      m_lock  = -1;
      m_count = 0;
      m_err   = e_arb_err_none;
      for (int i = 0; i < NS; i++) m_age[i] = 0;
`ifdef BP_LCE_RESP_ARB_STATS_EN
      m_stall   = 0;
      m_bgrants = 0;
`endif
    end else begin
      if (m_lock >= 0 && !v[m_lock] && m_err == e_arb_err_none) m_err = e_arb_err_retract;
`ifdef BP_LCE_RESP_ARB_STATS_EN
      if (e_v && !rdy && m_stall != 32'hffff_ffff) m_stall++;
      if (e_v && rdy && b && m_bgrants != 16'hffff) m_bgrants++;
`endif
      m_lock       = (e_v && !rdy) ? g : -1;
      m_lock_boost = b;
      for (int i = 0; i < NS; i++)
        m_age[i] = (!v[i] || m_yumi[i]) ? 0 : ((m_age[i] < SL) ? m_age[i] + 1 : SL);
      n = m_count + ((rv && rr) ? 1 : 0) - $countones(ret);
      if (n < 0 || n > MC) begin
        n = (n < 0) ? 0 : MC;
        if (m_err == e_arb_err_none) m_err = e_arb_err_credit;
      end
      m_count = n;
    end
  endtask

  logic [NS-1:0] rnd_v;
  logic [NR-1:0] rnd_ret;

  initial begin
    for (int i = 0; i < NS; i++) m_age[i] = 0;
    m_count = 0;
    m_yumi  = '0;
`ifdef BP_LCE_RESP_ARB_STATS_EN
    m_stall   = 0;
    m_bgrants = 0;
`endif
    reset = 1'b1; src_v = '0; src_resp = '0; lce_resp_ready = 1'b0;
    req_v = 1'b0; req_ready = 1'b0; credit_return = '0;

    // Reset state
    cycle('0, 0, 0, 0, '0, 1);
    cycle('1, 1, 1, 1, '1, 1);
    cycle('0, 0, 0, 0, '0, 0);
    check("reset_count", credit_count, 0);
    check("reset_empty", credits_empty, 1);

    // Priority
    cycle(3'b011, 1, 0, 0, '0, 0);
    check("prio_yumi0", src_yumi, 3'b001);
    cycle(3'b010, 1, 0, 0, '0, 0);
    check("prio_yumi1", src_yumi, 3'b010);

    // Lock on src1, src0 arrives but src1 still completes first
    cycle(3'b010, 0, 0, 0, '0, 0);
    cycle(3'b010, 0, 0, 0, '0, 0);
    cycle(3'b010, 0, 0, 0, '0, 0);
    cycle(3'b011, 1, 0, 0, '0, 0);
    check("lock_yumi", src_yumi, 3'b010);
    cycle(3'b011, 1, 0, 0, '0, 0);
    check("lock_after", src_yumi, 3'b001);

    // Starvation: src1 promoted on its 4th waiting cycle
    cycle('0, 0, 0, 0, '0, 1);
    for (int k = 0; k < 6; k++) begin
      cycle(3'b011, 1, 0, 0, '0, 0);
      if (k == 3) begin
        check("starve_yumi", src_yumi, 3'b010);
        check("starve_boost", boost, 1);
      end
    end

    // Credits: fill, net send+return, overflow at full
    cycle('0, 0, 0, 0, '0, 1);
    for (int k = 0; k < MC; k++) cycle('0, 0, 1, 1, '0, 0);
    cycle('0, 0, 1, 1, 4'b0011, 0);
    check("fill_count", credit_count, MC);
    check("fill_full", credits_full, 1);
    cycle('0, 0, 0, 0, '0, 0);
    check("net_count", credit_count, MC - 1);
    cycle('0, 0, 1, 1, '0, 0);
    cycle('0, 0, 1, 1, '0, 0);
    cycle('0, 0, 0, 0, '0, 0);
    check("ovf_count", credit_count, MC);
    check("ovf_err", credit_err, 1);

    // Underflow from 1, error sticky until reset
    cycle('0, 0, 0, 0, '0, 1);
    cycle('0, 0, 1, 1, '0, 0);
    cycle('0, 0, 0, 0, 4'b1111, 0);
    for (int k = 0; k < 3; k++) cycle('0, 0, 0, 0, '0, 0);
    check("unf_empty", credits_empty, 1);
    check("unf_err_sticky", credit_err, 1);
    cycle('0, 0, 0, 0, '0, 1);
    cycle('0, 0, 0, 0, '0, 0);
    check("unf_err_clear", credit_err, 0);

    // Reset mid-lock
    cycle(3'b010, 0, 1, 1, '0, 0);
    cycle(3'b010, 0, 0, 0, '0, 0);
    cycle(3'b010, 1, 0, 0, '0, 1);
    check("rst_lock_v", lce_resp_v, 0);
    check("rst_lock_yumi", src_yumi, 0);
    cycle(3'b011, 1, 0, 0, '0, 0);
    check("rst_lock_src0", src_yumi, 3'b001);
    check("rst_lock_count", credit_count, 0);

    // Retraction while locked raises the error flag
    cycle(3'b100, 0, 0, 0, '0, 0);
    cycle(3'b000, 0, 0, 0, '0, 0);
    cycle(3'b000, 0, 0, 0, '0, 0);
    check("retract_err", credit_err, 1);
    cycle('0, 0, 0, 0, '0, 1);

    // Random traffic: held-until-consumed sources, biased credit traffic
    rnd_v = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NS; i++) begin
        if (rnd_v[i] && !m_yumi[i])
          rnd_v[i] = ($urandom_range(0, 299) != 0);
        else
          rnd_v[i] = ($urandom_range(0, 99) < 50);
      end
      for (int j = 0; j < NR; j++)
        rnd_ret[j] = ($urandom_range(0, 99) < ((m_count > MC / 2) ? 25 : 8));
      cycle(rnd_v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 8), rnd_ret, ($urandom_range(0, 149) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
